// File: rtl/comb_y1_pkg.sv
// Shared constants for the comb_y1 logic-function block.
package comb_y1_pkg;

  // Truth table indexed by {A,B,C}: Y = A&B | ~A&C.
  localparam logic [7:0] Y1_TT     = 8'hCA;
  // Default width of the high-cycle counter.
  localparam int unsigned CNT_W_DEF = 16;

endpackage

// File: rtl/y1_edge_cnt.sv
// Registered copy of Y, rising-edge pulse and saturating high-cycle counter.
module y1_edge_cnt #(
  parameter int unsigned CNT_W = comb_y1_pkg::CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             y,
  input  logic             clr,
  output logic             y_q,
  output logic             y_rise,
  output logic [CNT_W-1:0] hi_cnt
);

  // Register Y, detect its 0->1 transition and count cycles with y_q high.
  // The counter holds at all-ones; clr overrides counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q    <= 1'b0;
      y_rise <= 1'b0;
      hi_cnt <= '0;
    end else begin
      y_q    <= y;
      y_rise <= y & ~y_q;
      if (clr) begin
        hi_cnt <= '0;
      end else if (y_q && (hi_cnt != '1)) begin
        hi_cnt <= hi_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/comb_y1.sv
// Three-input truth-table function with registered/edge/count side outputs.
module comb_y1
  import comb_y1_pkg::*;
#(
  parameter logic [7:0]  TRUTH = Y1_TT,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             clr,
  output logic             Y,
  output logic             y_q,
  output logic             y_rise,
  output logic [CNT_W-1:0] hi_cnt
);

  // Pure lookup; X/Z on an index bit propagates to Y.
  always_comb begin
    Y = TRUTH[{A, B, C}];
  end

  y1_edge_cnt #(
    .CNT_W (CNT_W)
  ) u_edge_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .y      (Y),
    .clr    (clr),
    .y_q    (y_q),
    .y_rise (y_rise),
    .hi_cnt (hi_cnt)
  );

endmodule

// File: tb/tb_comb_y1.sv
// Directed self-checking bench for comb_y1 (default width and CNT_W=4).
module tb_comb_y1;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst_n = 1'b0;
  logic        A = 1'b0, B = 1'b0, C = 1'b0;
  logic        clr = 1'b0;

  logic        y16, yq16, yr16;
  logic [15:0] cnt16;
  logic        y4, yq4, yr4;
  logic [3:0]  cnt4;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  comb_y1 dut16 (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .clr(clr),
    .Y(y16), .y_q(yq16), .y_rise(yr16), .hi_cnt(cnt16)
  );

  comb_y1 #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .clr(clr),
    .Y(y4), .y_q(yq4), .y_rise(yr4), .hi_cnt(cnt4)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_abc(input logic [2:0] v);
    {A, B, C} = v;
  endtask

  task automatic check_regs(input string tag, input logic q, input logic r,
                            input logic [15:0] c16, input logic [3:0] c4);
    check({tag, ".y_q"},     {31'd0, yq16}, {31'd0, q});
    check({tag, ".y_rise"},  {31'd0, yr16}, {31'd0, r});
    check({tag, ".cnt16"},   {16'd0, cnt16}, {16'd0, c16});
    check({tag, ".y_q4"},    {31'd0, yq4},  {31'd0, q});
    check({tag, ".y_rise4"}, {31'd0, yr4},  {31'd0, r});
    check({tag, ".cnt4"},    {28'd0, cnt4}, {28'd0, c4});
  endtask

  logic exp_y [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    // Exhaustive sweep, clock idle, reset held.
    for (int i = 0; i < 8; i++) begin
      set_abc(3'(i));
      #10;
      check($sformatf("sweep%0d.Y", i), {31'd0, y16}, {31'd0, exp_y[i]});
      check($sformatf("sweep%0d.Y4", i), {31'd0, y4}, {31'd0, exp_y[i]});
    end

    // In reset with 110: Y immediate, registers cleared.
    set_abc(3'b110);
    #1;
    check("rst.Y", {31'd0, y16}, 32'd1);
    check_regs("rst", 1'b0, 1'b0, 16'd0, 4'd0);

    clk_en = 1'b1;
    tick();
    check_regs("rst_edge", 1'b0, 1'b0, 16'd0, 4'd0);
    rst_n = 1'b1;
    tick();  // E1: Y already 1 -> rise
    check_regs("e1", 1'b1, 1'b1, 16'd0, 4'd0);
    tick();  // E2
    check_regs("e2", 1'b1, 1'b0, 16'd1, 4'd1);
    set_abc(3'b000);
    tick();  // E3: y_q falls, count from old y_q
    check_regs("e3", 1'b0, 1'b0, 16'd2, 4'd2);
    tick();
    check_regs("e4", 1'b0, 1'b0, 16'd2, 4'd2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_regs("clr0", 1'b0, 1'b0, 16'd0, 4'd0);

    // Hold 111 for 5 cycles, then 100.
    set_abc(3'b111);
    tick();
    check_regs("h1", 1'b1, 1'b1, 16'd0, 4'd0);
    for (int i = 2; i <= 5; i++) tick();
    check_regs("h5", 1'b1, 1'b0, 16'd4, 4'd4);
    set_abc(3'b100);
    #1;
    check("h.Y100", {31'd0, y16}, 32'd0);
    tick();
    check_regs("h6", 1'b0, 1'b0, 16'd5, 4'd5);
    tick();
    check_regs("h7", 1'b0, 1'b0, 16'd5, 4'd5);

    // clr pulse while y_q=1.
    set_abc(3'b111);
    tick();
    check_regs("c1", 1'b1, 1'b1, 16'd5, 4'd5);
    tick();
    check_regs("c2", 1'b1, 1'b0, 16'd6, 4'd6);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_regs("c3", 1'b1, 1'b0, 16'd0, 4'd0);
    tick();
    check_regs("c4", 1'b1, 1'b0, 16'd1, 4'd1);

    // Saturation on the 4-bit instance; clear wins at saturation.
    for (int i = 0; i < 20; i++) tick();
    check_regs("sat", 1'b1, 1'b0, 16'd21, 4'd15);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_regs("satclr", 1'b1, 1'b0, 16'd0, 4'd0);
    tick();
    check_regs("satres", 1'b1, 1'b0, 16'd1, 4'd1);

    // Asynchronous reset between edges; Y keeps following inputs.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_regs("arst", 1'b0, 1'b0, 16'd0, 4'd0);
    set_abc(3'b001);
    #1;
    check("arst.Y001", {31'd0, y16}, 32'd1);
    set_abc(3'b010);
    #1;
    check("arst.Y010", {31'd0, y16}, 32'd0);
    tick();
    check_regs("arst_edge", 1'b0, 1'b0, 16'd0, 4'd0);
    rst_n = 1'b1;
    set_abc(3'b011);
    tick();
    check_regs("post", 1'b1, 1'b1, 16'd0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
